// File: rtl/gray_pixel_writer_pkg.sv
// rtl/gray_pixel_writer_pkg.sv - shared state encoding, pixel widths and default frame geometry
package gray_pixel_writer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CH_W  = 4;
  localparam int PIX_W = 3 * CH_W;

  localparam int DEF_H_PIXELS   = 640;
  localparam int DEF_V_LINES    = 480;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_ADDR_W     = 19;

endpackage

// File: rtl/gray_pixel_writer_fifo.sv
// rtl/gray_pixel_writer_fifo.sv - pixel_fifo: power-of-two synchronous FIFO with full/empty/count
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Guards keep the FIFO consistent even if a caller ignores the flags.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gray_pixel_writer.sv
// rtl/gray_pixel_writer.sv - buffers ALU pixels and writes one RGB444 frame per start into a linear frame buffer
module gray_pixel_writer
  import gray_pixel_writer_pkg::*;
#(
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int V_LINES    = DEF_V_LINES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   rData,
  input  logic [CH_W-1:0]   gData,
  input  logic [CH_W-1:0]   bData,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              frame_done
);

  localparam int TOTAL      = H_PIXELS * V_LINES;
  localparam int CNT_W      = $clog2(TOTAL + 1);
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_accept_cnt;
  logic [ADDR_W-1:0]       r_addr;

  logic                    w_active;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [FIFO_CNT_W-1:0]   w_fifo_count;
  logic [PIX_W-1:0]        w_fifo_head;

  assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);

  // in_ready looks only at registered state, never at mem_ack.
  assign in_ready = (r_state == S_RUN) && !w_fifo_full && (r_accept_cnt < TOTAL_CNT);
  assign w_push   = in_valid && in_ready;

  assign mem_we     = w_active && !w_fifo_empty;
  assign mem_wdata  = w_fifo_head;
  assign mem_addr   = r_addr;
  assign w_pop      = mem_we && mem_ack;

  assign busy       = w_active;
  assign frame_done = (r_state == S_DONE);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({rData, gData, bData}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_push && (r_accept_cnt == LAST_CNT)) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave on the edge that retires the last entry so frame_done follows the final ack directly.
        if (w_fifo_empty || ((w_fifo_count == FIFO_CNT_W'(1)) && w_pop)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_accept_cnt <= '0;
      r_addr       <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_accept_cnt <= '0;
      r_addr       <= '0;
    end else begin
      if (w_push) begin
        r_accept_cnt <= r_accept_cnt + 1'b1;
      end
      // The final pop leaves the address parked on the last pixel instead of running past the frame.
      if (w_pop && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

endmodule

// File: doc/gray_pixel_writer.md
Name: gray_pixel_writer

Overview:
- Downstream stage of the grayscale ALU. Consumes the 4-bit R/G/B triplet produced by the adder stage. When alu_en is high, all three channels carry the same gray value.
- Buffers pixels in a small FIFO and writes them as 12-bit RGB444 words into a linear frame buffer.
- Address runs 0 .. H_PIXELS*V_LINES-1 for one frame per start pulse.
- Decouples the ALU pixel rate from memory write acceptance via valid/ready on input and we/ack on output.

Parameters:
- H_PIXELS, 640, pixels per line.
- V_LINES, 480, lines per frame.
- FIFO_DEPTH, 4, pixel buffer entries; power of two, >=2.
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a frame; honoured only in IDLE.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- rData  input  4  red/gray channel from adder.
- gData  input  4  green/gray channel from adder.
- bData  input  4  blue/gray channel from adder.
- mem_we  output  1  write request to frame buffer.
- mem_addr  output  ADDR_W  write address.
- mem_wdata  output  12  write data, {r,g,b}.
- mem_ack  input  1  memory accepted the current write this cycle.
- busy  output  1  high in RUN and DRAIN.
- frame_done  output  1  one-cycle pulse when the last pixel of a frame has been acked.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE. in_ready, mem_we, busy and frame_done are 0. mem_addr, mem_wdata, FIFO count and pointers, and accept counter are all 0. Reset mid-frame abandons the frame with no frame_done.
- TOTAL = H_PIXELS*V_LINES.
- IDLE: in_ready=0, mem_we=0. start=1 -> RUN next cycle; accept counter and write address cleared.
- RUN:
  - in_ready = !fifo_full && (accept_cnt < TOTAL).
  - Input handshake: a pixel is accepted when in_valid && in_ready. It is pushed as {rData,gData,bData} and accept_cnt increments.
  - When the accepted pixel is number TOTAL -> DRAIN next cycle.
- DRAIN: in_ready=0. When the FIFO is empty and no write is outstanding -> DONE.
- DONE: frame_done=1 for exactly one cycle, busy=0 -> IDLE.
- start is ignored outside IDLE, including start in the same cycle as frame_done.
- Write side, active in RUN and DRAIN:
  - mem_we = !fifo_empty. mem_wdata = FIFO head. mem_addr = write counter.
  - mem_we, mem_addr and mem_wdata stay stable until mem_ack.
  - On mem_we && mem_ack: pop the FIFO and increment the address.
  - mem_ack while mem_we=0 is ignored.
- Latency: a pixel accepted at edge N is visible on mem_we/mem_wdata after edge N (cycle N+1). There is no combinational path from in_valid to mem_we.
- Simultaneous push and pop: allowed whenever the FIFO is non-empty; occupancy is unchanged.
- Full FIFO: in_ready=0 even if mem_ack is high that cycle. in_ready must not depend combinationally on mem_ack.
- Pointers wrap modulo FIFO_DEPTH. The address never exceeds TOTAL-1 and does not wrap within a frame.
- The address restarts at 0 on each start.
- Channel data passes unmodified. No arithmetic beyond the counters. Counters are wide enough to hold TOTAL.

Decomposition:
- Shared package holds:
  - state encoding IDLE/RUN/DRAIN/DONE;
  - the RGB444 pixel word width (12) and channel width (4);
  - default frame geometry constants.
- One sub-module: pixel_fifo. Parameterised depth, synchronous push/pop, full/empty flags, same clk/rst_n.
- The FSM, counters and address generation stay in gray_pixel_writer.

Test Plan (H_PIXELS=4, V_LINES=2, FIFO_DEPTH=4, ADDR_W=3 unless noted):
- Reset mid-frame: after 3 accepted pixels, rst_n=0 for one cycle -> all outputs 0, state IDLE, no frame_done. A new start writes from addr 0.
- Streaming, mem_ack tied 1, in_valid tied 1, pixels r=g=b=k for k=0..7:
  - start -> writes addr k with wdata {k,k,k}; e.g. addr 5 -> 12'h555.
  - frame_done pulses once, 1 cycle after the final ack; busy falls with it.
- Backpressure, mem_ack=0 for 10 cycles:
  - in_ready drops after exactly 4 accepts.
  - mem_addr=0 and mem_wdata stay stable throughout.
  - After mem_ack rises, in_ready returns 1 the cycle after the first pop.
- Ordering: random in_valid and random mem_ack -> the write sequence is addresses 0..7 in accept order with matching data. Exactly 8 acked writes, then frame_done.
- start ignored: start pulses during RUN and DRAIN and on the frame_done cycle -> no restart, address continues; only a start in IDLE begins a new frame at addr 0.
- Excess input: in_valid held high after 8 accepts -> in_ready=0, no 9th accept, no write to addr 0 until the next start.
